array_decoder_seq: RTL and testbench
====================================

Name: array_decoder_seq

Overview:
- Parametrised successor of the array column decoder for the Bayesian memristor likelihood arrays.
- Accepts column commands over a valid/ready handshake and decodes the top address bits to one array, or broadcasts to all arrays.
- Sequences the CSL/CBLEN/CBL control bits through timed setup, pulse and relax phases.
- Drives one registered control word per array: {sel, CBLEN, CBL, CSL, col_addr}.

Parameters:
- NWORD, 3, column address width inside one array.
- NARRAY, 2, array-select address width; number of arrays NA = 2**NARRAY.
- N, NWORD+NARRAY, full column address width.
- PW_W, 8, width of the pulse-length field.
- SETUP_CYC, 1, cycles of setup (CSL/CBLEN on, CBL off) before the pulse; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid & ready.
- cmd_adr  in  N  [N-1:NWORD] array index; [NWORD-1:0] column.
- cmd_bcast  in  1  select all NA arrays; ignores the array index.
- cmd_cbl, cmd_cblen, cmd_csl  in  1 each  requested control levels.
- cmd_pw  in  PW_W  CBL pulse length in cycles; 0 is treated as 1.
- read_out  in  1  read-out mode; disables all selection.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse on normal completion.
- reg_lcs  out  NA x (NWORD+4)  per-array word: [NWORD+3] sel, [NWORD+2] CBLEN, [NWORD+1] CBL, [NWORD] CSL, [NWORD-1:0] col.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all reg_lcs=0; done=0; busy=0; cmd_ready=0 while rst=1.
  - Internal latches (address, levels, pulse count) cleared.
- cmd_ready = (state==IDLE) & !read_out & !rst. Commands presented while not ready are ignored, not queued.
- Accept at edge E0 latches the command. The selection mask is onehot(cmd_adr[N-1:NWORD]), or all ones if cmd_bcast.
- FSM:
  - IDLE -> SETUP on accept.
  - SETUP, SETUP_CYC cycles: selected words = {1, cmd_cblen, 0, cmd_csl, col}.
  - SETUP -> PULSE. PULSE, max(cmd_pw,1) cycles: selected words = {1, cmd_cblen, cmd_cbl, cmd_csl, col}.
  - PULSE -> RELAX. RELAX, 1 cycle: CBL=0; CSL/CBLEN as in SETUP.
  - RELAX -> IDLE. done=1 for exactly the first IDLE cycle. Selected words = {1, 0, 0, 0, col}, held until the next command or read_out.
- Outputs are registered. The first SETUP word is visible in the cycle after E0. busy spans SETUP_CYC + max(cmd_pw,1) + 1 cycles.
- Non-selected arrays:
  - sel bit = 0 from the SETUP entry onward.
  - CBLEN/CBL/CSL = 0.
  - col field retains its previous value.
- A control bit in a selected word is its commanded level gated by phase. No other array ever sees a control bit set.
- read_out=1 in any state: next edge clears all reg_lcs to 0 and sets state=IDLE. Any running sequence is aborted, with no done pulse. cmd_ready stays 0 until read_out=0.
- Back-to-back: during the done cycle state==IDLE, so a new command may be accepted in that same cycle; its SETUP follows with no gap.
- cmd_valid & read_out in the same cycle: not accepted.
- Pulse counter: a PW_W-bit down counter loaded with max(cmd_pw,1). PULSE exits when the counter reaches 1. No wrap.
- Reset mid-PULSE: all outputs return to 0 immediately (async). No done pulse.

Decomposition:
- Package array_decoder_pkg:
  - state enum {IDLE, SETUP, PULSE, RELAX}.
  - Bit-index localparams SEL_B, CBLEN_B, CBL_B, CSL_B (relative to NWORD).
  - Function build_lc(sel, cblen, cbl, csl, col).
- Sub-module pulse_timer: loadable PW_W-bit down counter with load/en inputs and an expire output. Shared by the SETUP and PULSE phases.

Test Plan:
- Reset: rst=1 with random inputs -> all reg_lcs=0, cmd_ready=0, busy=0; after release with read_out=0 -> cmd_ready=1.
- Single command: adr=5'b10_101, cbl=cblen=csl=1, pw=3, SETUP_CYC=1 -> reg_lcs[2] = 7'b1101101 x1, 7'b1111101 x3, 7'b1101101 x1, then 7'b1000101 with done=1. Other arrays sel=0, CBLEN/CBL/CSL=0. busy high for 5 cycles.
- Broadcast and pw=0: bcast=1, col=3'b011, csl=1 only, pw=0 -> all 4 words 7'b1001011 x1, 7'b1001011 x1 (PULSE, CBL level 0), 7'b1001011 x1, then 7'b1000011 with done.
- Abort: read_out=1 during the 2nd PULSE cycle -> next cycle all reg_lcs=0, no done, cmd_ready=0; read_out=0 -> cmd_ready=1 and prior col fields read as 0.
- Back-to-back: cmd_valid held with adr 5'b00_001 then 5'b11_110 -> second command accepted in the first command's done cycle; reg_lcs[3] enters SETUP the next cycle; reg_lcs[0] sel drops to 0 with col=3'b001 retained.
- Busy ignore: cmd_valid pulses during PULSE with a different adr -> ignored; the original sequence completes unchanged and exactly one done is seen.

Source files
------------

// File: rtl/array_decoder_pkg.sv
// Shared definitions for the array column decoder: FSM state codes, bit
// positions of the control flags inside a per-array word, and a helper that
// assembles one control word.
package array_decoder_pkg;

    // Sequencer states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] RELAX = 2'd3;

    // Control-flag offsets above the column field (word bit = NWORD + offset)
    localparam int SEL_B   = 3;
    localparam int CBLEN_B = 2;
    localparam int CBL_B   = 1;
    localparam int CSL_B   = 0;

    // Widest word the helper can build; callers size-cast the result down
    localparam int LC_MAX_W  = 36;
    localparam int COL_MAX_W = LC_MAX_W - 4;

    // Assemble {sel, cblen, cbl, csl, col} for a column field nword bits wide.
    // col must be zero-extended by the caller so the flag bits land cleanly.
    function automatic logic [LC_MAX_W-1:0] build_lc(
        input logic                 sel,
        input logic                 cblen,
        input logic                 cbl,
        input logic                 csl,
        input logic [COL_MAX_W-1:0] col,
        input int                   nword
    );
        logic [LC_MAX_W-1:0] w;
        w = {4'b0000, col};
        w[nword + SEL_B]   = sel;
        w[nword + CBLEN_B] = cblen;
        w[nword + CBL_B]   = cbl;
        w[nword + CSL_B]   = csl;
        return w;
    endfunction

endpackage

// File: rtl/array_decoder_seq_pulse_timer.sv
// Loadable down counter timing the SETUP and PULSE phases. expire is high
// while the count is at its last cycle (1); the counter never wraps.
module pulse_timer #(
    parameter int PW_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            en,
    input  logic [PW_W-1:0] load_val,
    output logic            expire
);

    logic [PW_W-1:0] count;

    // Load has priority; decrement only while above 1 so the count parks there
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count > PW_W'(1))) begin
            count <= count - PW_W'(1);
        end
    end

    assign expire = (count <= PW_W'(1));

endmodule

// File: rtl/array_decoder_seq.sv
// Column decoder/sequencer for the memristor likelihood arrays. Accepts one
// command at a time, selects one array (or all on broadcast) and walks the
// selected control words through SETUP, PULSE and RELAX before parking them.
module array_decoder_seq
    import array_decoder_pkg::*;
#(
    parameter int NWORD     = 3,
    parameter int NARRAY    = 2,
    parameter int N         = NWORD + NARRAY,
    parameter int PW_W      = 8,
    parameter int SETUP_CYC = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [N-1:0]                          cmd_adr,
    input  logic                                  cmd_bcast,
    input  logic                                  cmd_cbl,
    input  logic                                  cmd_cblen,
    input  logic                                  cmd_csl,
    input  logic [PW_W-1:0]                       cmd_pw,
    input  logic                                  read_out,
    output logic                                  busy,
    output logic                                  done,
    output logic [(2**NARRAY)-1:0][NWORD+3:0]     reg_lcs
);

    localparam int NA   = 2**NARRAY;
    localparam int LC_W = NWORD + 4;

    logic [1:0]                 state, state_n;
    logic                       done_n;
    logic                       accept;

    // Command fields latched at accept
    logic [NA-1:0]              sel_mask;
    logic [NWORD-1:0]           col_q;
    logic                       cbl_q, cblen_q, csl_q;
    logic [PW_W-1:0]            pw_q;

    // Incoming command, decoded
    logic [NA-1:0]              mask_in;
    logic [PW_W-1:0]            pw_eff_in;

    // Fields that apply to the next cycle's words
    logic [NA-1:0]              mask_n;
    logic [NWORD-1:0]           col_n;
    logic                       cbl_n, cblen_n, csl_n;
    logic [3:0]                 ctl_n;
    logic [NA-1:0][LC_W-1:0]    lc_n;

    logic                       timer_load, timer_en, timer_expire;
    logic [PW_W-1:0]            timer_val;

    assign cmd_ready = (state == IDLE) && !read_out && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign mask_in   = cmd_bcast ? {NA{1'b1}} : (NA'(1) << cmd_adr[N-1:NWORD]);
    assign pw_eff_in = (cmd_pw == '0) ? PW_W'(1) : cmd_pw;

    pulse_timer #(
        .PW_W     (PW_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    // Phase sequencing and timer control; read_out overrides everything
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_n    = state;
        done_n     = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timer_val  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = SETUP;
                    timer_load = 1'b1;
                    timer_val  = PW_W'(SETUP_CYC);
                end
            end
            SETUP: begin
                if (timer_expire) begin
                    state_n    = PULSE;
                    timer_load = 1'b1;
                    timer_val  = pw_q;
                end else begin
                    timer_en   = 1'b1;
                end
            end
            PULSE: begin
                if (timer_expire) state_n = RELAX;
                else              timer_en = 1'b1;
            end
            default: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        endcase
        if (read_out) begin
            state_n    = IDLE;
            done_n     = 1'b0;
            timer_load = 1'b0;
            timer_en   = 1'b0;
        end
    end

    // Next control words: selected arrays follow the phase, others keep col
    always_comb begin
        mask_n  = accept ? mask_in              : sel_mask;
        col_n   = accept ? cmd_adr[NWORD-1:0]   : col_q;
        cbl_n   = accept ? cmd_cbl              : cbl_q;
        cblen_n = accept ? cmd_cblen            : cblen_q;
        csl_n   = accept ? cmd_csl              : csl_q;
        ctl_n   = 4'b1000;
        case (state_n)
            SETUP:   ctl_n = {1'b1, cblen_n, 1'b0,  csl_n};
            PULSE:   ctl_n = {1'b1, cblen_n, cbl_n, csl_n};
            RELAX:   ctl_n = {1'b1, cblen_n, 1'b0,  csl_n};
            default: ctl_n = 4'b1000;
        endcase
        for (int i = 0; i < NA; i++) begin
            if (mask_n[i]) begin
                lc_n[i] = LC_W'(build_lc(ctl_n[SEL_B], ctl_n[CBLEN_B], ctl_n[CBL_B],
                                         ctl_n[CSL_B], COL_MAX_W'(col_n), NWORD));
            end else begin
                lc_n[i] = {4'b0000, reg_lcs[i][NWORD-1:0]};
            end
        end
    end

    // State, latched command and the registered per-array output words
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the output word array is a small register bank, not a RAM,
        // and must read as zero out of reset, so it is reset like any flop.
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            sel_mask <= '0;
            col_q    <= '0;
            cbl_q    <= 1'b0;
            cblen_q  <= 1'b0;
            csl_q    <= 1'b0;
            pw_q     <= '0;
            reg_lcs  <= '0;
        end else begin
            state <= state_n;
            done  <= done_n;
            if (accept) begin
                sel_mask <= mask_in;
                col_q    <= cmd_adr[NWORD-1:0];
                cbl_q    <= cmd_cbl;
                cblen_q  <= cmd_cblen;
                csl_q    <= cmd_csl;
                pw_q     <= pw_eff_in;
            end
            if (read_out) begin
                reg_lcs <= '0;
            end else if (accept || (state != IDLE)) begin
                reg_lcs <= lc_n;
            end
        end
    end

endmodule

// File: tb/tb_array_decoder_seq.sv
// Scoreboard bench for array_decoder_seq: a watcher turns each accepted
// command into its expected per-cycle trace, a monitor compares every cycle.
module tb_array_decoder_seq;

    localparam int NWORD     = 3;
    localparam int NARRAY    = 2;
    localparam int N         = NWORD + NARRAY;
    localparam int PW_W      = 8;
    localparam int SETUP_CYC = 1;
    localparam int NA        = 2**NARRAY;
    localparam int LC_W      = NWORD + 4;

    typedef logic [NA-1:0][LC_W-1:0] lcs_t;
    typedef struct packed {
        lcs_t lcs;
        logic busy;
        logic done;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready;
    logic [N-1:0]     cmd_adr;
    logic             cmd_bcast, cmd_cbl, cmd_cblen, cmd_csl;
    logic [PW_W-1:0]  cmd_pw;
    logic             read_out;
    logic             busy, done;
    lcs_t             reg_lcs;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    lcs_t mlcs = '0;     // words the DUT should hold while idle

    array_decoder_seq #(
        .NWORD     (NWORD),
        .NARRAY    (NARRAY),
        .N         (N),
        .PW_W      (PW_W),
        .SETUP_CYC (SETUP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_adr   (cmd_adr),
        .cmd_bcast (cmd_bcast),
        .cmd_cbl   (cmd_cbl),
        .cmd_cblen (cmd_cblen),
        .cmd_csl   (cmd_csl),
        .cmd_pw    (cmd_pw),
        .read_out  (read_out),
        .busy      (busy),
        .done      (done),
        .reg_lcs   (reg_lcs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected words: selected arrays carry ctl/col, others keep their col
    function automatic lcs_t mk(input logic [NA-1:0] m, input logic [NWORD-1:0] c,
                                input logic [3:0] ctl);
        lcs_t r;
        for (int i = 0; i < NA; i++)
            r[i] = m[i] ? {ctl, c} : {4'b0000, mlcs[i][NWORD-1:0]};
        return r;
    endfunction

    // Watcher: an accepted command becomes a trace of expected cycles
    exp_t             pend_q[$];
    logic [NA-1:0]    w_m;
    logic [NWORD-1:0] w_c;
    int               w_pw;
    lcs_t             w_final;
    always begin
        @(negedge clk);
        if (cmd_valid && cmd_ready) begin
            pend_q.delete();
            for (int i = 0; i < NA; i++)
                w_m[i] = cmd_bcast || (i == int'(cmd_adr[N-1:NWORD]));
            w_c  = cmd_adr[NWORD-1:0];
            w_pw = (cmd_pw == 0) ? 1 : int'(cmd_pw);
            for (int k = 0; k < SETUP_CYC; k++)
                pend_q.push_back('{mk(w_m, w_c, {1'b1, cmd_cblen, 1'b0, cmd_csl}), 1'b1, 1'b0});
            for (int k = 0; k < w_pw; k++)
                pend_q.push_back('{mk(w_m, w_c, {1'b1, cmd_cblen, cmd_cbl, cmd_csl}), 1'b1, 1'b0});
            pend_q.push_back('{mk(w_m, w_c, {1'b1, cmd_cblen, 1'b0, cmd_csl}), 1'b1, 1'b0});
            w_final = mk(w_m, w_c, 4'b1000);
            pend_q.push_back('{w_final, 1'b0, 1'b1});
            @(posedge clk);
            #1;
            foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
            mlcs = w_final;
        end
    end

    // Monitor: pop one expected cycle per clock, or expect the idle hold
    exp_t mon_e;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("lcs",  64'(reg_lcs), 64'(mon_e.lcs));
            check("busy", 64'(busy),    64'(mon_e.busy));
            check("done", 64'(done),    64'(mon_e.done));
        end else begin
            check("idle_lcs",  64'(reg_lcs), 64'(mlcs));
            check("idle_busy", 64'(busy),    64'd0);
            check("idle_done", 64'(done),    64'd0);
        end
    end

    // Present a command from the post-edge phase and hold until accepted
    task automatic send(input logic [N-1:0] adr, input logic bc, input logic cbl,
                        input logic cblen, input logic csl, input logic [PW_W-1:0] pw);
        bit ok = 1'b0;
        cmd_adr   = adr;
        cmd_bcast = bc;
        cmd_cbl   = cbl;
        cmd_cblen = cblen;
        cmd_csl   = csl;
        cmd_pw    = pw;
        cmd_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the sequence to end and the scoreboard to drain
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (!busy && !done && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        // Reset with random inputs
        rst       = 1'b1;
        cmd_valid = 1'($urandom);
        cmd_adr   = N'($urandom);
        cmd_bcast = 1'($urandom);
        cmd_cbl   = 1'($urandom);
        cmd_cblen = 1'($urandom);
        cmd_csl   = 1'($urandom);
        cmd_pw    = PW_W'($urandom);
        read_out  = 1'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("rst_lcs",   64'(reg_lcs),   64'd0);
            check("rst_ready", 64'(cmd_ready), 64'd0);
            check("rst_busy",  64'(busy),      64'd0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        read_out  = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single command to array 2, column 5, all levels, pw=3
        send(5'b10_101, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3);
        wait_idle();
        check("single_final_a2", 64'(reg_lcs[2]), 64'(7'b1000101));
        check("single_final_a0", 64'(reg_lcs[0]), 64'd0);

        // Broadcast, csl only, pw=0 treated as 1
        send(5'b00_011, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        wait_idle();
        for (int i = 0; i < NA; i++)
            check("bcast_final", 64'(reg_lcs[i]), 64'(7'b1000011));

        // Abort with read_out during the second PULSE cycle
        d0 = done_cnt;
        send(5'b01_110, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4);
        repeat (SETUP_CYC + 1) @(posedge clk);
        #1;
        read_out = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        mlcs = '0;
        @(negedge clk);
        check("abort_lcs",   64'(reg_lcs),   64'd0);
        check("abort_done",  64'(done),      64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd0);
        check("abort_busy",  64'(busy),      64'd0);
        @(posedge clk);
        #1;
        read_out = 1'b0;
        @(negedge clk);
        check("abort_ready_back", 64'(cmd_ready), 64'd1);
        check("abort_no_done",    64'(done_cnt - d0), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back: second command taken in the first one's done cycle
        send(5'b00_001, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
        send(5'b11_110, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
        wait_idle();
        check("b2b_a0_kept", 64'(reg_lcs[0]), 64'(7'b0000001));
        check("b2b_a3",      64'(reg_lcs[3]), 64'(7'b1000110));

        // Commands offered while busy are ignored
        d0 = done_cnt;
        send(5'b01_010, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
        repeat (SETUP_CYC + 1) @(posedge clk);
        #1;
        cmd_adr   = 5'b10_111;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle();
        check("ignore_one_done", 64'(done_cnt - d0), 64'd1);
        check("ignore_a1",       64'(reg_lcs[1]),    64'(7'b1000010));

        // Asynchronous reset in the middle of PULSE
        send(5'b11_011, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
        repeat (SETUP_CYC + 1) @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        mlcs = '0;
        #1;
        check("midrst_lcs",  64'(reg_lcs), 64'd0);
        check("midrst_busy", 64'(busy),    64'd0);
        check("midrst_done", 64'(done),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // Random commands, some back-to-back
        for (int n = 0; n < 40; n++) begin
            send(N'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), PW_W'($urandom_range(0, 5)));
            if ($urandom_range(0, 2) != 0) begin
                wait_idle();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
